// File: rtl/toggle_rx_pkg.sv
// Shared types and constants for the toggle-handshake receiver.
package toggle_rx_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_CNT_W  = 16;
  localparam int unsigned SYNC_DEPTH = 2;

endpackage

// File: rtl/toggle_handshake_rx_if.sv
// Bundle of the toggle request/ack pair and the downstream valid/ready port.
interface toggle_handshake_rx_if
  import toggle_rx_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned CNT_W  = DEF_CNT_W
);

  logic              req_tgl;
  logic [DATA_W-1:0] req_data;
  logic              ack_tgl;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;
  logic [CNT_W-1:0]  event_count;
  logic              overrun;

  modport master (
    output req_tgl, req_data, out_ready,
    input  ack_tgl, out_valid, out_data, event_count, overrun
  );

  modport slave (
    input  req_tgl, req_data, out_ready,
    output ack_tgl, out_valid, out_data, event_count, overrun
  );

endinterface

// File: rtl/toggle_edge_detect.sv
// Turns each level change of the request toggle into a one-cycle detect pulse.
// TOGGLE_RX_SYNC_EN selects a 2-flop synchroniser for a cross-domain sender.
module toggle_edge_detect
  import toggle_rx_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic tgl_i,
  output logic detect_o
);

  logic sampled;
  logic prev_q;

`ifdef TOGGLE_RX_SYNC_EN
  logic [SYNC_DEPTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_DEPTH-2:0], tgl_i};
    end
  end

  assign sampled = sync_q[SYNC_DEPTH-1];
`else
  logic sample_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_q <= 1'b0;
    end else begin
      sample_q <= tgl_i;
    end
  end

  assign sampled = sample_q;
`endif

  // prev always follows the sample, so a dropped toggle is never re-detected
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= sampled;
    end
  end

  assign detect_o = sampled ^ prev_q;

endmodule

// File: rtl/toggle_handshake_rx.sv
// Toggle-handshake receiver: captures each request word, presents it on valid/ready,
// toggles ack on acceptance, counts transfers and flags overruns.
module toggle_handshake_rx
  import toggle_rx_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned CNT_W  = DEF_CNT_W
)(
  input  logic                 clk,
  input  logic                 rst_n,
  toggle_handshake_rx_if.slave bus
);

  logic              detect;
  state_e            state_q;
  logic              ack_q;
  logic              valid_q;
  logic              ovr_q;
  logic [DATA_W-1:0] data_q;
  logic [CNT_W-1:0]  cnt_q;

  toggle_edge_detect u_edge (
    .clk      (clk),
    .rst_n    (rst_n),
    .tgl_i    (bus.req_tgl),
    .detect_o (detect)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ack_q   <= 1'b0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (detect) begin
            data_q  <= bus.req_data;
            valid_q <= 1'b1;
            state_q <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (bus.out_ready) begin
            ack_q <= ~ack_q;
            cnt_q <= cnt_q + 1'b1;
            // back-to-back: complete the held word and capture the next one in the same edge
            if (detect) begin
              data_q <= bus.req_data;
            end else begin
              valid_q <= 1'b0;
              state_q <= ST_IDLE;
            end
          end else if (detect) begin
            ovr_q <= 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.ack_tgl     = ack_q;
  assign bus.out_valid   = valid_q;
  assign bus.out_data    = data_q;
  assign bus.event_count = cnt_q;
  assign bus.overrun     = ovr_q;

endmodule

// File: tb/tb_toggle_handshake_rx.sv
// Self-checking bench for toggle_handshake_rx: table of transfers plus corner-case sequences,
// with a second instance at CNT_W=4 sharing the same stimulus to exercise counter wrap.
module tb_toggle_handshake_rx;

`ifdef TOGGLE_RX_SYNC_EN
  localparam int unsigned LAT = 3;
`else
  localparam int unsigned LAT = 2;
`endif

  logic clk;
  logic rst_n;

  toggle_handshake_rx_if #(.DATA_W(8), .CNT_W(16)) bus ();
  toggle_handshake_rx_if #(.DATA_W(8), .CNT_W(4))  bus4 ();

  assign bus4.req_tgl   = bus.req_tgl;
  assign bus4.req_data  = bus.req_data;
  assign bus4.out_ready = bus.out_ready;

  toggle_handshake_rx #(.DATA_W(8), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  toggle_handshake_rx #(.DATA_W(8), .CNT_W(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  din;
    int unsigned dly;
    logic [7:0]  exp_data;
  } vec_t;

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [7:0]  dq[$];
  logic        exp_ack = 1'b0;
  logic        exp_ovr = 1'b0;
  int unsigned exp_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_state(input string tag);
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_data"},  32'(bus.out_data), 32'd0);
    chk({tag, "_ack"},   32'(bus.ack_tgl), 32'd0);
    chk({tag, "_cnt"},   32'(bus.event_count), 32'd0);
    chk({tag, "_ovr"},   32'(bus.overrun), 32'd0);
  endtask

  // ready must already be high; takes the accepting edge and checks its effects
  task automatic accept(input logic exp_valid_after);
    logic [7:0] e;
    if (dq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL acc_queue: got empty want entry at %0t", $time);
      e = '0;
    end else begin
      e = dq.pop_front();
    end
    chk("acc_valid", 32'(bus.out_valid), 32'd1);
    chk("acc_data", 32'(bus.out_data), 32'(e));
    tick();
    exp_ack = ~exp_ack;
    exp_cnt++;
    chk("ack", 32'(bus.ack_tgl), 32'(exp_ack));
    chk("cnt", 32'(bus.event_count), exp_cnt % 65536);
    chk("cnt4", 32'(bus4.event_count), exp_cnt % 16);
    chk("valid_after", 32'(bus.out_valid), 32'(exp_valid_after));
    chk("ovr", 32'(bus.overrun), 32'(exp_ovr));
  endtask

  task automatic send(input logic [7:0] d);
    bus.req_data = d;
    bus.req_tgl  = ~bus.req_tgl;
  endtask

  task automatic xfer(input logic [7:0] d, input int unsigned dly);
    send(d);
    dq.push_back(d);
    bus.out_ready = (dly == 0);
    repeat (LAT - 1) tick();
    chk("lat_early", 32'(bus.out_valid), 32'd0);
    tick();
    chk("lat_valid", 32'(bus.out_valid), 32'd1);
    for (int unsigned i = 0; i < dly; i++) begin
      chk("hold_valid", 32'(bus.out_valid), 32'd1);
      chk("hold_data", 32'(bus.out_data), 32'(d));
      chk("hold_ack", 32'(bus.ack_tgl), 32'(exp_ack));
      tick();
    end
    bus.out_ready = 1'b1;
    accept(1'b0);
    bus.out_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    bus.req_tgl   = 1'b0;
    bus.req_data  = '0;
    bus.out_ready = 1'b0;
    dq.delete();
    exp_ack = 1'b0;
    exp_ovr = 1'b0;
    exp_cnt = 0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    vec_t vecs[6];
    vecs = '{
      '{din: 8'hA5, dly: 0, exp_data: 8'hA5},
      '{din: 8'h3C, dly: 5, exp_data: 8'h3C},
      '{din: 8'h00, dly: 1, exp_data: 8'h00},
      '{din: 8'hFF, dly: 0, exp_data: 8'hFF},
      '{din: 8'h81, dly: 2, exp_data: 8'h81},
      '{din: 8'h5A, dly: 0, exp_data: 8'h5A}
    };

    do_reset();
    for (int unsigned i = 0; i < 10; i++) begin
      chk_idle_state("idle");
      tick();
    end

    foreach (vecs[i]) begin
      xfer(vecs[i].din, vecs[i].dly);
      chk("vec_data_kept", 32'(bus.out_data), 32'(vecs[i].exp_data));
    end

    // toggle landing on the accepting edge
    bus.out_ready = 1'b0;
    send(8'h11);
    dq.push_back(8'h11);
    repeat (LAT) tick();
    chk("sim_first_valid", 32'(bus.out_valid), 32'd1);
    send(8'h22);
    dq.push_back(8'h22);
    repeat (LAT - 1) tick();
    bus.out_ready = 1'b1;
    accept(1'b1);
    chk("sim_new_data", 32'(bus.out_data), 32'h22);
    accept(1'b0);
    bus.out_ready = 1'b0;

    // second toggle while holding, no ready
    send(8'h77);
    dq.push_back(8'h77);
    repeat (LAT) tick();
    chk("ovr_first_valid", 32'(bus.out_valid), 32'd1);
    chk("ovr_pre", 32'(bus.overrun), 32'd0);
    send(8'h88);
    repeat (LAT + 2) tick();
    exp_ovr = 1'b1;
    chk("ovr_set", 32'(bus.overrun), 32'd1);
    chk("ovr_data_kept", 32'(bus.out_data), 32'h77);
    chk("ovr_ack_held", 32'(bus.ack_tgl), 32'(exp_ack));
    bus.out_ready = 1'b1;
    accept(1'b0);
    bus.out_ready = 1'b0;
    repeat (5) tick();
    chk("ovr_single_ack", 32'(bus.ack_tgl), 32'(exp_ack));
    chk("ovr_no_redetect", 32'(bus.out_valid), 32'd0);
    chk("ovr_sticky", 32'(bus.overrun), 32'd1);
    chk("ovr_cnt", 32'(bus.event_count), exp_cnt % 65536);

    // asynchronous reset while holding a word
    send(8'h99);
    dq.push_back(8'h99);
    repeat (LAT) tick();
    chk("rst_pre_valid", 32'(bus.out_valid), 32'd1);
    #2;
    rst_n       = 1'b0;
    bus.req_tgl = 1'b0;
    #1;
    chk("rst_async_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_async_valid4", 32'(bus4.out_valid), 32'd0);
    dq.delete();
    exp_ack = 1'b0;
    exp_ovr = 1'b0;
    exp_cnt = 0;
    repeat (2) tick();
    rst_n = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      tick();
      chk_idle_state("post_rst");
    end

    // counter wrap on the CNT_W=4 instance
    for (int unsigned i = 0; i < 17; i++) begin
      xfer(8'($urandom_range(0, 255)), 0);
    end
    chk("wrap_cnt4", 32'(bus4.event_count), 32'd1);
    chk("wrap_cnt16", 32'(bus.event_count), 32'd17);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
